dm_responder: RTL and testbench

Data-memory responder that sits on the far side of the processor's DM port: it accepts the word read/write requests the core issues on DM_read/DM_write/DM_enable/DM_address/DM_in and returns read data on DM_out. It holds a word-organised RAM, a small memory-mapped peripheral window (cycle counter, status, scratch), a post-reset RAM-clearing sequencer and sticky fault capture for illegal accesses.

---
 rtl/dm_responder_if.sv | 22 ++
 rtl/dm_responder.sv | 124 ++++++++++++
 tb/tb_dm_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// DM port bundle between the processor core (master) and the data-memory responder (slave).
interface dm_responder_if;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic [11:0] DM_address;
  logic [31:0] DM_in;
  logic [31:0] DM_out;
  logic        init_busy;
  logic        fault;
  logic [11:0] fault_addr;

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, init_busy, fault, fault_addr
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in,
    output DM_out, init_busy, fault, fault_addr
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word RAM, CYCLE/STATUS/SCRATCH window, post-reset RAM clear
// sequencer and sticky capture of the first illegal access.
//
// state  | meaning
// S_INIT | clearing RAM one word per cycle, requests ignored
// S_RUN  | normal operation until the next rst
module dm_responder #(
  parameter int          DEPTH      = 1020,
  parameter logic [31:0] CYCLE_INIT = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave dm
);
  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
  localparam logic [11:0]     RAM_END = 12'(DEPTH * 4);
  localparam logic [11:0]     A_CYC   = 12'hFF0;
  localparam logic [11:0]     A_STAT  = 12'hFF4;
  localparam logic [11:0]     A_SCR   = 12'hFF8;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             init_busy_q;
  logic [31:0]      dout_q;
  logic             fault_q;
  logic [11:0]      fault_addr_q;
  logic [31:0]      cycle_q;
  logic [31:0]      cycle_d;
  logic [31:0]      scratch_q;
  logic [31:0]      mem_q [DEPTH];

  logic [PTR_W-1:0] widx;
  logic             req, is_ram, is_cyc, is_stat, is_scr, bad, good;
  logic [31:0]      rdata;

  assign widx    = dm.DM_address[PTR_W+1:2];
  assign cycle_d = cycle_q + 32'd1;

  always_comb begin
    req     = 1'b0;
    is_ram  = 1'b0;
    is_cyc  = 1'b0;
    is_stat = 1'b0;
    is_scr  = 1'b0;
    bad     = 1'b0;
    good    = 1'b0;
    rdata   = 32'h0;
    req     = dm.DM_enable && (state_q == S_RUN) && (dm.DM_read || dm.DM_write);
    is_ram  = dm.DM_address < RAM_END;
    is_cyc  = dm.DM_address == A_CYC;
    is_stat = dm.DM_address == A_STAT;
    is_scr  = dm.DM_address == A_SCR;
    // Misalignment faults even when the word would otherwise decode.
    bad     = req && ((dm.DM_address[1:0] != 2'b00) ||
                      !(is_ram || is_cyc || is_stat || is_scr));
    good    = req && !bad;
    if (is_ram)       rdata = mem_q[widx];
    else if (is_cyc)  rdata = cycle_q;
    else if (is_stat) rdata = {30'b0, fault_q, init_busy_q};
    else if (is_scr)  rdata = scratch_q;
  end

  // RAM has no reset; the INIT pass owns clearing it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT)
        mem_q[ptr_q] <= 32'h0;
      else if (good && dm.DM_write && is_ram)
        mem_q[widx] <= dm.DM_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      init_busy_q  <= 1'b1;
      dout_q       <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 12'h0;
      cycle_q      <= CYCLE_INIT;
      scratch_q    <= 32'h0;
    end else begin
      cycle_q <= cycle_d;
      case (state_q)
        S_INIT: begin
          dout_q <= 32'h0;
          ptr_q  <= ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_q     <= S_RUN;
            init_busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (req && dm.DM_read)
            dout_q <= bad ? 32'h0 : rdata;
          if (good && dm.DM_write) begin
            if (is_scr)
              scratch_q <= dm.DM_in;
            if (is_stat && dm.DM_in[0]) begin
              fault_q      <= 1'b0;
              fault_addr_q <= 12'h0;
            end
          end
          // Placed after the clear so a same-edge fault takes precedence.
          if (bad) begin
            fault_q <= 1'b1;
            if (!fault_q)
              fault_addr_q <= dm.DM_address;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign dm.DM_out     = dout_q;
  assign dm.init_busy  = init_busy_q;
  assign dm.fault      = fault_q;
  assign dm.fault_addr = fault_addr_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (DEPTH=16), with a second instance
// whose cycle counter starts near wrap.
module tb_dm_responder;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] v1, v2;

  always #5 clk = ~clk;

  dm_responder_if bus();
  dm_responder_if bus_w();

  dm_responder #(.DEPTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .dm  (bus)
  );

  dm_responder #(.DEPTH(16), .CYCLE_INIT(32'hFFFF_FFEF)) u_wrap (
    .clk (clk),
    .rst (rst),
    .dm  (bus_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [31:0] data);
    bus.DM_enable  = en;
    bus.DM_read    = rd;
    bus.DM_write   = wr;
    bus.DM_address = addr;
    bus.DM_in      = data;
  endtask

  task automatic drive_w(input logic en, input logic rd, input logic [11:0] addr);
    bus_w.DM_enable  = en;
    bus_w.DM_read    = rd;
    bus_w.DM_write   = 1'b0;
    bus_w.DM_address = addr;
    bus_w.DM_in      = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    drive_w(1'b0, 1'b0, 12'h000);
    tick();
    tick();
    chk("rst_dout",      bus.DM_out,     32'h0);
    chk("rst_busy",      bus.init_busy,  32'h1);
    chk("rst_fault",     bus.fault,      32'h0);
    chk("rst_faddr",     bus.fault_addr, 32'h0);

    // Wrap instance keeps a CYCLE read pending through INIT; it must stay ignored.
    drive_w(1'b1, 1'b1, 12'hFF0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("init_busy_e%0d", i), bus.init_busy, (i < 16) ? 32'h1 : 32'h0);
      if (i == 8) chk("wrap_dout_init", bus_w.DM_out, 32'h0);
    end
    chk("wrap_fault_init", bus_w.fault, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    tick();
    chk("wrap_cyc_ffffffff", bus_w.DM_out, 32'hFFFF_FFFF);
    chk("ram0_zero",         bus.DM_out,   32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h004, 32'h0);
    tick();
    chk("wrap_cyc_00000000", bus_w.DM_out, 32'h0000_0000);
    drive_w(1'b0, 1'b0, 12'h000);
    for (int i = 2; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 12'(4 * i), 32'h0);
      tick();
      chk($sformatf("ram_zero_%0d", i), bus.DM_out, 32'h0);
    end

    drive(1'b1, 1'b0, 1'b1, 12'h008, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
    tick();
    chk("rd_008", bus.DM_out, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 1'b0, 12'h00C, 32'h0);
    tick();
    chk("rd_disabled_hold", bus.DM_out, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 12'h00C, 32'h1234_5678);
    tick();
    chk("wr_only_hold", bus.DM_out, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b0, 12'h00C, 32'h0);
    tick();
    chk("rd_00c", bus.DM_out, 32'h1234_5678);

    drive(1'b1, 1'b0, 1'b1, 12'h010, 32'h1111_1111);
    tick();
    drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h2222_2222);
    tick();
    chk("rbw_old", bus.DM_out, 32'h1111_1111);
    drive(1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
    tick();
    chk("rbw_new", bus.DM_out, 32'h2222_2222);

    drive(1'b1, 1'b0, 1'b1, 12'h006, 32'h0000_0BAD);
    tick();
    chk("mis_fault", bus.fault,      32'h1);
    chk("mis_faddr", bus.fault_addr, 32'h006);
    drive(1'b1, 1'b1, 1'b0, 12'h004, 32'h0);
    tick();
    chk("mis_ram_004", bus.DM_out, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
    tick();
    chk("mis_ram_008", bus.DM_out, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b0, 12'hFC0, 32'h0);
    tick();
    chk("unmapped_dout", bus.DM_out,     32'h0);
    chk("sticky_faddr",  bus.fault_addr, 32'h006);
    chk("sticky_fault",  bus.fault,      32'h1);
    drive(1'b1, 1'b1, 1'b0, 12'hFF4, 32'h0);
    tick();
    chk("status_fault", bus.DM_out, 32'h2);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 32'h0000_0001);
    tick();
    chk("clr_fault", bus.fault,      32'h0);
    chk("clr_faddr", bus.fault_addr, 32'h0);

    drive(1'b1, 1'b0, 1'b1, 12'hFF8, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 1'b1, 1'b0, 12'hFF8, 32'h0);
    tick();
    chk("scratch", bus.DM_out, 32'hA5A5_A5A5);
    drive(1'b1, 1'b0, 1'b1, 12'hFF0, 32'h0);
    tick();
    chk("cyc_wr_nofault", bus.fault, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 12'hFF0, 32'h0);
    tick();
    v1 = bus.DM_out;
    tick();
    v2 = bus.DM_out;
    chk("cyc_delta", v2 - v1, 32'h1);

    // Restart mid-INIT at pointer 7 with a write pending throughout the new pass.
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk("mid_init_busy", bus.init_busy, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 12'h000, 32'hFFFF_FFFF);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("reinit_busy_e%0d", i), bus.init_busy, (i < 16) ? 32'h1 : 32'h0);
    end
    chk("reinit_nofault", bus.fault, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    tick();
    chk("reinit_ram0", bus.DM_out, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
    tick();
    chk("reinit_ram8", bus.DM_out, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'hFF8, 32'h0);
    tick();
    chk("reinit_scratch", bus.DM_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
